// File: rtl/std_cache_pkg.sv
// Shared types and constants for the data-cache ECC patrol scrubber.
// Per-byte decoder flag layout: two bits per byte, way-major ordering.
package std_cache_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_CHK,
        WB_REQ,
        NEXT
    } scrub_state_e;

    localparam int ERR_CE_BIT  = 0;
    localparam int ERR_UCE_BIT = 1;
    localparam int ERR_FLAG_W  = 2;

endpackage

// File: rtl/scrub_way_sel.sv
// Lowest-set-bit one-hot picker across cache ways.
module scrub_way_sel #(
    parameter int WAYS = 8
) (
    input  logic [WAYS-1:0] mask,
    output logic [WAYS-1:0] onehot
);

    // seen[i] is set when any lower-numbered way is already requesting
    logic [WAYS:0] seen;

    assign seen[0] = 1'b0;

    generate
        for (genvar gi = 0; gi < WAYS; gi++) begin : g_pick
            assign onehot[gi]   = mask[gi] & ~seen[gi];
            assign seen[gi + 1] = seen[gi] | mask[gi];
        end
    endgenerate

endmodule

// File: rtl/dcache_ecc_scrubber.sv
// Background patrol scrubber for the ECC-protected dcache data SRAMs.
// Define DCACHE_ECC_SCRUB_STATS_EN to keep error counters and last-error registers.
module dcache_ecc_scrubber #(
    parameter int DCACHE_SET_ASSOC = 8,
    parameter int INDEX_WIDTH      = 8,
    parameter int LINE_WIDTH       = 128,
    parameter int NBYTES           = (LINE_WIDTH + 7) / 8,
    parameter int SCRUB_INTERVAL   = 1024,
    parameter int CNT_WIDTH        = 16
) (
    input  logic                                    clk_i,
    input  logic                                    rst_i,
    input  logic                                    enable_i,
    output logic [DCACHE_SET_ASSOC-1:0]             req_o,
    input  logic                                    gnt_i,
    output logic [INDEX_WIDTH-1:0]                  addr_o,
    output logic                                    we_o,
    output logic [LINE_WIDTH-1:0]                   wdata_o,
    input  logic [DCACHE_SET_ASSOC*LINE_WIDTH-1:0]  rdata_i,
    input  logic [DCACHE_SET_ASSOC*NBYTES*2-1:0]    err_i,
    input  logic                                    conflict_i,
    output logic                                    ce_o,
    output logic                                    uce_o,
    output logic [DCACHE_SET_ASSOC-1:0]             err_way_o,
    output logic [INDEX_WIDTH-1:0]                  err_index_o,
    output logic [CNT_WIDTH-1:0]                    ce_cnt_o,
    output logic [CNT_WIDTH-1:0]                    uce_cnt_o
);

    import std_cache_pkg::*;

    localparam int IW = (SCRUB_INTERVAL > 1) ? $clog2(SCRUB_INTERVAL) : 1;
    localparam logic [IW-1:0] INTERVAL_LAST = IW'(SCRUB_INTERVAL - 1);

    scrub_state_e                state_reg, state_next;
    logic [INDEX_WIDTH-1:0]      index_reg, index_next;
    logic [IW-1:0]               interval_reg, interval_next;
    logic [DCACHE_SET_ASSOC-1:0] ce_mask_reg, ce_mask_next;
    logic [LINE_WIDTH-1:0]       line_reg [DCACHE_SET_ASSOC];
    logic                        capture_en;
    logic                        ce_pulse_reg, uce_pulse_reg;
    logic                        rep_ce, rep_uce;
    logic [DCACHE_SET_ASSOC-1:0] rd_ce_mask, rd_uce_mask, wb_onehot;
    logic [LINE_WIDTH-1:0]       wb_line;

    // A way is correctable only if some byte was fixed and no byte is beyond repair
    generate
        for (genvar gi = 0; gi < DCACHE_SET_ASSOC; gi++) begin : g_way_flags
            logic any_ce, any_uce;
            always_comb begin
                any_ce  = 1'b0;
                any_uce = 1'b0;
                for (int b = 0; b < NBYTES; b++) begin
                    any_ce  = any_ce  | err_i[(gi*NBYTES + b)*ERR_FLAG_W + ERR_CE_BIT];
                    any_uce = any_uce | err_i[(gi*NBYTES + b)*ERR_FLAG_W + ERR_UCE_BIT];
                end
            end
            assign rd_ce_mask[gi]  = any_ce & ~any_uce;
            assign rd_uce_mask[gi] = any_uce;
        end
    endgenerate

    scrub_way_sel #(.WAYS(DCACHE_SET_ASSOC)) u_wb_sel (
        .mask   (ce_mask_reg),
        .onehot (wb_onehot)
    );

    always_comb begin
        wb_line = '0;
        for (int w = 0; w < DCACHE_SET_ASSOC; w++) begin
            if (wb_onehot[w]) begin
                wb_line = wb_line | line_reg[w];
            end
        end
    end

    always_comb begin
        req_o   = '0;
        we_o    = 1'b0;
        wdata_o = '0;
        case (state_reg)
            RD_REQ: req_o = '1;
            WB_REQ: begin
                req_o   = wb_onehot;
                we_o    = 1'b1;
                wdata_o = wb_line;
            end
            default: ;
        endcase
    end

    assign addr_o = index_reg;
    assign ce_o   = ce_pulse_reg;
    assign uce_o  = uce_pulse_reg;

    always_comb begin
        state_next    = state_reg;
        index_next    = index_reg;
        interval_next = interval_reg;
        ce_mask_next  = ce_mask_reg;
        capture_en    = 1'b0;
        rep_ce        = 1'b0;
        rep_uce       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (!enable_i) begin
                    interval_next = '0;
                end else if (interval_reg == INTERVAL_LAST) begin
                    interval_next = '0;
                    state_next    = RD_REQ;
                end else begin
                    interval_next = interval_reg + 1'b1;
                end
            end
            RD_REQ: begin
                if (gnt_i) begin
                    state_next = RD_CHK;
                end
            end
            RD_CHK: begin
                if (conflict_i) begin
                    // Line changed underneath us: the read is stale, fetch again
                    ce_mask_next = '0;
                    state_next   = RD_REQ;
                end else begin
                    capture_en   = 1'b1;
                    rep_uce      = |rd_uce_mask;
                    ce_mask_next = rd_ce_mask;
                    state_next   = (|rd_ce_mask) ? WB_REQ : NEXT;
                end
            end
            WB_REQ: begin
                if (gnt_i) begin
                    rep_ce       = 1'b1;
                    ce_mask_next = ce_mask_reg & ~wb_onehot;
                    if ((ce_mask_reg & ~wb_onehot) == '0) begin
                        state_next = NEXT;
                    end
                end else if (conflict_i) begin
                    ce_mask_next = '0;
                    state_next   = RD_REQ;
                end
            end
            NEXT: begin
                index_next = index_reg + 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg     <= IDLE;
            index_reg     <= '0;
            interval_reg  <= '0;
            ce_mask_reg   <= '0;
            ce_pulse_reg  <= 1'b0;
            uce_pulse_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            index_reg     <= index_next;
            interval_reg  <= interval_next;
            ce_mask_reg   <= ce_mask_next;
            ce_pulse_reg  <= rep_ce;
            uce_pulse_reg <= rep_uce;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int w = 0; w < DCACHE_SET_ASSOC; w++) begin
                line_reg[w] <= '0;
            end
        end else if (capture_en) begin
            for (int w = 0; w < DCACHE_SET_ASSOC; w++) begin
                line_reg[w] <= rdata_i[w*LINE_WIDTH +: LINE_WIDTH];
            end
        end
    end

`ifdef DCACHE_ECC_SCRUB_STATS_EN
    logic [DCACHE_SET_ASSOC-1:0] uce_onehot;
    logic [DCACHE_SET_ASSOC-1:0] err_way_reg;
    logic [INDEX_WIDTH-1:0]      err_index_reg;
    logic [CNT_WIDTH-1:0]        ce_cnt_reg, uce_cnt_reg;

    scrub_way_sel #(.WAYS(DCACHE_SET_ASSOC)) u_uce_sel (
        .mask   (rd_uce_mask),
        .onehot (uce_onehot)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            err_way_reg   <= '0;
            err_index_reg <= '0;
            ce_cnt_reg    <= '0;
            uce_cnt_reg   <= '0;
        end else if (rep_ce) begin
            err_way_reg   <= wb_onehot;
            err_index_reg <= index_reg;
            if (ce_cnt_reg != '1) begin
                ce_cnt_reg <= ce_cnt_reg + 1'b1;
            end
        end else if (rep_uce) begin
            err_way_reg   <= uce_onehot;
            err_index_reg <= index_reg;
            if (uce_cnt_reg != '1) begin
                uce_cnt_reg <= uce_cnt_reg + 1'b1;
            end
        end
    end

    assign err_way_o   = err_way_reg;
    assign err_index_o = err_index_reg;
    assign ce_cnt_o    = ce_cnt_reg;
    assign uce_cnt_o   = uce_cnt_reg;
`else
    assign err_way_o   = '0;
    assign err_index_o = '0;
    assign ce_cnt_o    = '0;
    assign uce_cnt_o   = '0;
`endif

endmodule

// File: tb/tb_dcache_ecc_scrubber.sv
// Directed bench for dcache_ecc_scrubber with a small 4-set memory model.
module tb_dcache_ecc_scrubber;

    localparam int WAYS = 8;
    localparam int IDXW = 2;
    localparam int LW   = 128;
    localparam int NB   = 16;
    localparam int CW   = 16;
`ifdef DCACHE_ECC_SCRUB_STATS_EN
    localparam int STATS = 1;
`else
    localparam int STATS = 0;
`endif

    logic                 clk_i = 1'b0;
    logic                 rst_i = 1'b1;
    logic                 enable_i = 1'b0;
    logic [WAYS-1:0]      req_o;
    logic                 gnt_i;
    logic [IDXW-1:0]      addr_o;
    logic                 we_o;
    logic [LW-1:0]        wdata_o;
    logic [WAYS*LW-1:0]   rdata_i;
    logic [WAYS*NB*2-1:0] err_i;
    logic                 conflict_i = 1'b0;
    logic                 ce_o, uce_o;
    logic [WAYS-1:0]      err_way_o;
    logic [IDXW-1:0]      err_index_o;
    logic [CW-1:0]        ce_cnt_o, uce_cnt_o;

    logic                 gnt_en = 1'b1;
    logic                 hold_wr = 1'b0;
    logic [WAYS*NB*2-1:0] err_mem [4];
    logic [WAYS*NB*2-1:0] fix_mask [4];

    logic [IDXW-1:0]      rd_addr_q [$];
    logic [WAYS-1:0]      wr_way_q [$];
    logic [IDXW-1:0]      wr_addr_q [$];
    logic [LW-1:0]        wr_data_q [$];
    int                   ce_pulses, uce_pulses;
    int                   checks = 0;
    int                   failures = 0;

    dcache_ecc_scrubber #(
        .DCACHE_SET_ASSOC (WAYS),
        .INDEX_WIDTH      (IDXW),
        .LINE_WIDTH       (LW),
        .NBYTES           (NB),
        .SCRUB_INTERVAL   (4),
        .CNT_WIDTH        (CW)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .enable_i    (enable_i),
        .req_o       (req_o),
        .gnt_i       (gnt_i),
        .addr_o      (addr_o),
        .we_o        (we_o),
        .wdata_o     (wdata_o),
        .rdata_i     (rdata_i),
        .err_i       (err_i),
        .conflict_i  (conflict_i),
        .ce_o        (ce_o),
        .uce_o       (uce_o),
        .err_way_o   (err_way_o),
        .err_index_o (err_index_o),
        .ce_cnt_o    (ce_cnt_o),
        .uce_cnt_o   (uce_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    assign gnt_i = gnt_en && !(hold_wr && we_o);

    function automatic logic [LW-1:0] pat(input int w, input int idx);
        return {32'hDEAD_0000 | 32'(w << 4) | 32'(idx), 32'h1234_5678 ^ 32'(w),
                32'hCAFE_0000 + 32'(idx), 32'(w * idx + 7)};
    endfunction

    always_comb begin
        rdata_i = '0;
        for (int w = 0; w < WAYS; w++) begin
            rdata_i[w*LW +: LW] = pat(w, int'(addr_o));
        end
        err_i = err_mem[addr_o] & ~fix_mask[addr_o];
    end

    // Bus monitor: one line per granted read or write; granted writes repair the model
    always @(negedge clk_i) begin
        if (rst_i) begin
            rd_addr_q.delete();
            wr_way_q.delete();
            wr_addr_q.delete();
            wr_data_q.delete();
            ce_pulses  <= 0;
            uce_pulses <= 0;
            for (int i = 0; i < 4; i++) fix_mask[i] <= '0;
        end else begin
            if (ce_o) ce_pulses <= ce_pulses + 1;
            if (uce_o) uce_pulses <= uce_pulses + 1;
            if (gnt_i && req_o != '0 && !we_o) begin
                rd_addr_q.push_back(addr_o);
                $display("RD  index=%0d", addr_o);
            end
            if (gnt_i && we_o) begin
                wr_way_q.push_back(req_o);
                wr_addr_q.push_back(addr_o);
                wr_data_q.push_back(wdata_o);
                $display("WR  index=%0d way=%b data=%h", addr_o, req_o, wdata_o);
                for (int w = 0; w < WAYS; w++) begin
                    if (req_o[w]) begin
                        for (int b = 0; b < NB; b++) begin
                            fix_mask[addr_o][(w*NB + b)*2] <= 1'b1;
                        end
                    end
                end
            end
        end
    end

    task automatic check(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst_i      = 1'b1;
        enable_i   = 1'b0;
        conflict_i = 1'b0;
        hold_wr    = 1'b0;
        gnt_en     = 1'b1;
        for (int i = 0; i < 4; i++) err_mem[i] = '0;
        repeat (3) @(negedge clk_i);
        rst_i = 1'b0;
    endtask

    task automatic scrub_reads(input int n, input string tag);
        enable_i = 1'b1;
        for (int c = 0; c < 400 && rd_addr_q.size() < n; c++) @(negedge clk_i);
        check({tag, "_reads"}, LW'(rd_addr_q.size()), LW'(n));
        enable_i = 1'b0;
        repeat (12) @(negedge clk_i);
    endtask

    task automatic wait_we(input string tag);
        for (int c = 0; c < 200 && !we_o; c++) @(negedge clk_i);
        check({tag, "_we_seen"}, LW'(we_o), LW'(1));
    endtask

    initial begin
        for (int i = 0; i < 4; i++) err_mem[i] = '0;

        // Reset values
        repeat (2) @(negedge clk_i);
        check("rst_req", LW'(req_o), LW'(0));
        check("rst_we", LW'(we_o), LW'(0));
        check("rst_addr", LW'(addr_o), LW'(0));
        check("rst_wdata", wdata_o, LW'(0));
        check("rst_ce", LW'(ce_o), LW'(0));
        check("rst_uce", LW'(uce_o), LW'(0));
        check("rst_err_way", LW'(err_way_o), LW'(0));
        check("rst_err_index", LW'(err_index_o), LW'(0));
        check("rst_ce_cnt", LW'(ce_cnt_o), LW'(0));
        check("rst_uce_cnt", LW'(uce_cnt_o), LW'(0));

        // Clean sweep wraps the index
        do_reset();
        scrub_reads(5, "clean");
        for (int i = 0; i < 5 && i < rd_addr_q.size(); i++) begin
            check($sformatf("clean_addr%0d", i), LW'(rd_addr_q[i]), LW'(i % 4));
        end
        check("clean_writes", LW'(wr_way_q.size()), LW'(0));
        check("clean_ce_cnt", LW'(ce_cnt_o), LW'(0));
        check("clean_uce_cnt", LW'(uce_cnt_o), LW'(0));

        // Single correctable byte: way 2 byte 5 at index 1
        do_reset();
        err_mem[1][(2*NB + 5)*2] = 1'b1;
        scrub_reads(2, "ce1");
        check("ce1_writes", LW'(wr_way_q.size()), LW'(1));
        if (wr_way_q.size() > 0) begin
            check("ce1_way", LW'(wr_way_q[0]), LW'(8'b0000_0100));
            check("ce1_addr", LW'(wr_addr_q[0]), LW'(1));
            check("ce1_data", wr_data_q[0], pat(2, 1));
        end
        check("ce1_pulses", LW'(ce_pulses), LW'(1));
        check("ce1_uce_pulses", LW'(uce_pulses), LW'(0));
        check("ce1_ce_cnt", LW'(ce_cnt_o), LW'(STATS));
        check("ce1_err_index", LW'(err_index_o), LW'(STATS));
        check("ce1_err_way", LW'(err_way_o), LW'(STATS * 4));

        // Ways 0 and 3 correctable at index 0: written lowest way first
        do_reset();
        err_mem[0][(0*NB + 3)*2]  = 1'b1;
        err_mem[0][(3*NB + 15)*2] = 1'b1;
        scrub_reads(1, "ce2");
        check("ce2_writes", LW'(wr_way_q.size()), LW'(2));
        if (wr_way_q.size() > 1) begin
            check("ce2_way0", LW'(wr_way_q[0]), LW'(8'b0000_0001));
            check("ce2_way1", LW'(wr_way_q[1]), LW'(8'b0000_1000));
            check("ce2_data1", wr_data_q[1], pat(3, 0));
        end
        check("ce2_pulses", LW'(ce_pulses), LW'(2));
        check("ce2_ce_cnt", LW'(ce_cnt_o), LW'(STATS * 2));
        check("ce2_err_way", LW'(err_way_o), LW'(STATS * 8));

        // Way 1 uncorrectable byte 0 plus corrected byte 2: report only
        do_reset();
        err_mem[0][(1*NB + 0)*2 + 1] = 1'b1;
        err_mem[0][(1*NB + 2)*2]     = 1'b1;
        scrub_reads(1, "uce");
        check("uce_writes", LW'(wr_way_q.size()), LW'(0));
        check("uce_pulses", LW'(uce_pulses), LW'(1));
        check("uce_ce_pulses", LW'(ce_pulses), LW'(0));
        check("uce_uce_cnt", LW'(uce_cnt_o), LW'(STATS));
        check("uce_ce_cnt", LW'(ce_cnt_o), LW'(0));
        check("uce_err_way", LW'(err_way_o), LW'(STATS * 2));
        check("uce_err_index", LW'(err_index_o), LW'(0));

        // Conflict while writeback waits for grant: re-read finds clean line
        do_reset();
        err_mem[0][(4*NB + 1)*2] = 1'b1;
        hold_wr  = 1'b1;
        enable_i = 1'b1;
        wait_we("cfl");
        check("cfl_wb_req", LW'(req_o), LW'(8'b0001_0000));
        conflict_i = 1'b1;
        err_mem[0] = '0;
        @(negedge clk_i);
        conflict_i = 1'b0;
        hold_wr    = 1'b0;
        check("cfl_back_to_rd", LW'(req_o), LW'(8'hFF));
        scrub_reads(2, "cfl");
        if (rd_addr_q.size() > 1) begin
            check("cfl_reread_addr", LW'(rd_addr_q[1]), LW'(0));
        end
        check("cfl_writes", LW'(wr_way_q.size()), LW'(0));
        check("cfl_ce_pulses", LW'(ce_pulses), LW'(0));
        check("cfl_ce_cnt", LW'(ce_cnt_o), LW'(0));

        // Grant withheld in RD_REQ: request held stable
        do_reset();
        gnt_en   = 1'b0;
        enable_i = 1'b1;
        for (int c = 0; c < 200 && req_o == '0; c++) @(negedge clk_i);
        for (int c = 0; c < 10; c++) begin
            check("hold_req", LW'(req_o), LW'(8'hFF));
            check("hold_addr", LW'(addr_o), LW'(0));
            check("hold_we", LW'(we_o), LW'(0));
            @(negedge clk_i);
        end
        gnt_en = 1'b1;
        scrub_reads(1, "hold");

        // Reset during a stalled writeback abandons it
        do_reset();
        err_mem[0][(5*NB + 0)*2] = 1'b1;
        hold_wr  = 1'b1;
        enable_i = 1'b1;
        wait_we("rstwb");
        check("rstwb_wdata_pre", wdata_o, pat(5, 0));
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;
        check("rstwb_req", LW'(req_o), LW'(0));
        check("rstwb_we", LW'(we_o), LW'(0));
        check("rstwb_wdata", wdata_o, LW'(0));
        check("rstwb_addr", LW'(addr_o), LW'(0));
        check("rstwb_ce", LW'(ce_o), LW'(0));
        check("rstwb_ce_cnt", LW'(ce_cnt_o), LW'(0));
        check("rstwb_err_way", LW'(err_way_o), LW'(0));
        @(negedge clk_i);
        check("rstwb_writes", LW'(wr_way_q.size()), LW'(0));
        rst_i    = 1'b0;
        enable_i = 1'b0;
        hold_wr  = 1'b0;
        repeat (2) @(negedge clk_i);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
